// File: rtl/ultrasonic_pkg.sv
// Shared types, constants and level arithmetic for the ultrasonic control slice.
package ultrasonic_pkg;

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_IDLE   = 2'd1,
    S_TX     = 2'd2,
    S_LISTEN = 2'd3
  } us_state_e;

  // One captured command word from the decoder (amount travels separately).
  typedef struct packed {
    logic valid;
    logic on;
    logic off;
    logic inc;
    logic dec;
    logic send;
    logic recv;
  } us_cmd_t;

  localparam int ECHO_TIME_W = 16;
  // Wide enough for AMOUNT_WIDTH+1 bit sums up to AMOUNT_WIDTH = 16.
  localparam int LVL_CALC_W  = 17;

  // Saturating level update; simultaneous increase and decrease cancel out.
  function automatic logic [LVL_CALC_W-1:0] level_step(
    input logic [LVL_CALC_W-1:0] lvl,
    input logic [LVL_CALC_W-1:0] amt,
    input logic [LVL_CALC_W-1:0] lmax,
    input logic                  inc,
    input logic                  dec
  );
    logic [LVL_CALC_W-1:0] r;
    r = lvl;
    if (inc && !dec) begin
      r = lvl + amt;
      if (r > lmax) r = lmax;
      else          r = r;
    end else if (dec && !inc) begin
      if (amt > lvl) r = {LVL_CALC_W{1'b0}};
      else           r = lvl - amt;
    end else begin
      r = lvl;
    end
    return r;
  endfunction

endpackage

// File: rtl/ultrasonic_ctrl_if.sv
// Command and status bundle between the command decoder side and ultrasonic_ctrl.
interface ultrasonic_ctrl_if
  import ultrasonic_pkg::*;
#(
  parameter int AMOUNT_WIDTH = 8
);
  logic                    on;
  logic                    off;
  logic                    increase;
  logic                    decrease;
  logic                    send;
  logic                    receive;
  logic                    valid;
  logic [AMOUNT_WIDTH-1:0] amount;
  logic                    echo_in;
  logic                    powered;
  logic [AMOUNT_WIDTH-1:0] level;
  logic                    busy;
  logic                    tx_out;
  logic [AMOUNT_WIDTH-1:0] tx_amp;
  logic                    echo_detected;
  logic                    timeout;
  logic [ECHO_TIME_W-1:0]  echo_time;

  modport master (
    output on, off, increase, decrease, send, receive, valid, amount, echo_in,
    input  powered, level, busy, tx_out, tx_amp, echo_detected, timeout, echo_time
  );

  modport slave (
    input  on, off, increase, decrease, send, receive, valid, amount, echo_in,
    output powered, level, busy, tx_out, tx_amp, echo_detected, timeout, echo_time
  );
endinterface

// File: rtl/us_burst_gen.sv
// Fixed-length square-wave burst: BURST_LEN periods of HALF_PERIOD high / HALF_PERIOD low.
// tx_out_o is high in the first cycle after start_i; done_o flags the last burst cycle.
module us_burst_gen #(
  parameter int HALF_PERIOD = 4,
  parameter int BURST_LEN   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic abort_i,
  output logic tx_out_o,
  output logic done_o
);
  localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int PW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(BURST_LEN - 1);

  logic          active_q, active_d;
  logic          tx_q, tx_d;
  logic [HW-1:0] half_q, half_d;
  logic [PW-1:0] per_q, per_d;

  assign tx_out_o = tx_q;
  assign done_o   = active_q & ~tx_q & (half_q == HALF_LAST) & (per_q == PER_LAST);

  // Half-period and period counting; abort wins over start.
  always_comb begin
    active_d = active_q;
    tx_d     = tx_q;
    half_d   = half_q;
    per_d    = per_q;
    if (abort_i) begin
      active_d = 1'b0;
      tx_d     = 1'b0;
      half_d   = '0;
      per_d    = '0;
    end else if (start_i) begin
      active_d = 1'b1;
      tx_d     = 1'b1;
      half_d   = '0;
      per_d    = '0;
    end else if (active_q) begin
      if (half_q == HALF_LAST) begin
        half_d = '0;
        if (tx_q) begin
          tx_d = 1'b0;
        end else if (per_q == PER_LAST) begin
          active_d = 1'b0;
          per_d    = '0;
        end else begin
          tx_d  = 1'b1;
          per_d = per_q + PW'(1);
        end
      end else begin
        half_d = half_q + HW'(1);
      end
    end else begin
      tx_d = 1'b0;
    end
  end

  // Burst state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      tx_q     <= 1'b0;
      half_q   <= '0;
      per_q    <= '0;
    end else begin
      active_q <= active_d;
      tx_q     <= tx_d;
      half_q   <= half_d;
      per_q    <= per_d;
    end
  end
endmodule

// File: rtl/ultrasonic_ctrl.sv
// Transducer control: power state, saturating drive level, TX bursts and echo timing.
// Optional feature macro: ECHO_SYNC_EN (2-flop synchronizer on echo_in).
// Commands are captured in a one-word register, so they act one cycle after sampling.
module ultrasonic_ctrl
  import ultrasonic_pkg::*;
#(
  parameter int AMOUNT_WIDTH  = 8,
  parameter int LEVEL_MAX     = 200,
  parameter int HALF_PERIOD   = 4,
  parameter int BURST_LEN     = 8,
  parameter int LISTEN_CYCLES = 64
) (
  input logic              clk,
  input logic              rst_n,
  ultrasonic_ctrl_if.slave us
);
  localparam logic [ECHO_TIME_W-1:0] CNT_LAST = ECHO_TIME_W'(LISTEN_CYCLES - 1);

  us_state_e               state_q, state_d;
  us_cmd_t                 cmd_q, cmd_d;
  logic [AMOUNT_WIDTH-1:0] amt_q;
  logic [AMOUNT_WIDTH-1:0] level_q, level_d;
  logic [AMOUNT_WIDTH-1:0] tx_amp_q, tx_amp_d;
  logic [ECHO_TIME_W-1:0]  cnt_q, cnt_d;
  logic [ECHO_TIME_W-1:0]  echo_time_q, echo_time_d;
  logic                    listen_req_q, listen_req_d;
  logic                    det_q, det_d, to_q, to_d;
  logic                    busy_q, powered_q;
  logic                    echo_s, echo_prev_q, echo_edge_s;
  logic                    burst_start_s, burst_done_s, tx_s;
  logic                    cv_on, cv_off, cv_inc, cv_dec, cv_send, cv_recv;

  assign cmd_d = '{valid: us.valid, on: us.on, off: us.off, inc: us.increase,
                   dec: us.decrease, send: us.send, recv: us.receive};

  assign cv_on   = cmd_q.valid & cmd_q.on;
  assign cv_off  = cmd_q.valid & cmd_q.off;
  assign cv_inc  = cmd_q.valid & cmd_q.inc;
  assign cv_dec  = cmd_q.valid & cmd_q.dec;
  assign cv_send = cmd_q.valid & cmd_q.send;
  assign cv_recv = cmd_q.valid & cmd_q.recv;

`ifdef ECHO_SYNC_EN
  logic [1:0] echo_sync_q;
  // Two-flop synchronizer for the asynchronous comparator output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) echo_sync_q <= 2'b00;
    else        echo_sync_q <= {echo_sync_q[0], us.echo_in};
  end
  assign echo_s = echo_sync_q[1];
`else
  assign echo_s = us.echo_in;
`endif

  // Rising edge against last cycle's sample; a level already high is not an edge.
  assign echo_edge_s = echo_s & ~echo_prev_q;

  us_burst_gen #(
    .HALF_PERIOD (HALF_PERIOD),
    .BURST_LEN   (BURST_LEN)
  ) u_burst (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (burst_start_s),
    .abort_i  (cv_off),
    .tx_out_o (tx_s),
    .done_o   (burst_done_s)
  );

  // Level tracking: honoured in every powered state unless the word also carries off.
  always_comb begin
    level_d = level_q;
    if (state_q != S_OFF && !cv_off) begin
      level_d = AMOUNT_WIDTH'(level_step(LVL_CALC_W'(level_q), LVL_CALC_W'(amt_q),
                                         LVL_CALC_W'(LEVEL_MAX), cv_inc, cv_dec));
    end else begin
      level_d = level_q;
    end
  end

  // Next-state, burst launch, listen timer and echo/timeout pulses.
  always_comb begin
    state_d       = state_q;
    listen_req_d  = listen_req_q;
    cnt_d         = cnt_q;
    echo_time_d   = echo_time_q;
    tx_amp_d      = tx_amp_q;
    det_d         = 1'b0;
    to_d          = 1'b0;
    burst_start_s = 1'b0;
    if (cv_off) begin
      state_d  = S_OFF;
      tx_amp_d = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          if (cv_on) state_d = S_IDLE;
          else       state_d = S_OFF;
        end
        S_IDLE: begin
          if (cv_send && level_q != '0) begin
            state_d       = S_TX;
            burst_start_s = 1'b1;
            tx_amp_d      = level_q;
            listen_req_d  = cv_recv;
          end else if (cv_recv && !cv_send) begin
            state_d = S_LISTEN;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_TX: begin
          if (burst_done_s) begin
            tx_amp_d = '0;
            if (listen_req_q) begin
              state_d = S_LISTEN;
              cnt_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_TX;
          end
        end
        S_LISTEN: begin
          // The cycle showing a pulse is the last LISTEN cycle.
          if (det_q || to_q) begin
            state_d = S_IDLE;
          end else if (echo_edge_s) begin
            det_d       = 1'b1;
            echo_time_d = cnt_q;
          end else if (cnt_q == CNT_LAST) begin
            to_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ECHO_TIME_W'(1);
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  // State, level, timer and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_OFF;
      cmd_q        <= '0;
      amt_q        <= '0;
      level_q      <= '0;
      tx_amp_q     <= '0;
      cnt_q        <= '0;
      echo_time_q  <= '0;
      listen_req_q <= 1'b0;
      det_q        <= 1'b0;
      to_q         <= 1'b0;
      busy_q       <= 1'b0;
      powered_q    <= 1'b0;
      echo_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      amt_q        <= us.amount;
      level_q      <= level_d;
      tx_amp_q     <= tx_amp_d;
      cnt_q        <= cnt_d;
      echo_time_q  <= echo_time_d;
      listen_req_q <= listen_req_d;
      det_q        <= det_d;
      to_q         <= to_d;
      busy_q       <= (state_d == S_TX) || (state_d == S_LISTEN);
      powered_q    <= (state_d != S_OFF);
      echo_prev_q  <= echo_s;
    end
  end

  assign us.powered       = powered_q;
  assign us.level         = level_q;
  assign us.busy          = busy_q;
  assign us.tx_out        = tx_s;
  assign us.tx_amp        = tx_amp_q;
  assign us.echo_detected = det_q;
  assign us.timeout       = to_q;
  assign us.echo_time     = echo_time_q;
endmodule

// File: doc/ultrasonic_ctrl.md
# ultrasonic_ctrl

Transducer control stage directly downstream of the command decoder. It consumes the decoder's registered command flags (on/off/increase/decrease/send/receive/valid, amount), tracks power state and a saturating drive level, fires fixed-length TX bursts and times the returning echo in a bounded listen window.

## Interface
- AMOUNT_WIDTH, 8: width of `amount`, `level` and `tx_amp`.
- LEVEL_MAX, 200: upper saturation bound for `level`; must be ≤ 2^AMOUNT_WIDTH−1.
- HALF_PERIOD, 4: cycles per TX half-period, ≥1.
- BURST_LEN, 8: full TX periods per burst, ≥1.
- LISTEN_CYCLES, 64: listen window length in cycles, 1..65535.

- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- on, off, increase, decrease, send, receive  in  1 each  decoded command flags, meaningful only when `valid`=1.
- valid  in  1  command qualifier; one command word per high cycle.
- amount  in  AMOUNT_WIDTH  level step for increase/decrease.
- echo_in  in  1  echo comparator output.
- powered  out  1  high in every state except OFF.
- level  out  AMOUNT_WIDTH  current drive level.
- busy  out  1  high in TX and LISTEN.
- tx_out  out  1  transducer drive square wave.
- tx_amp  out  AMOUNT_WIDTH  level latched at burst start; 0 outside TX.
- echo_detected  out  1  one-cycle pulse on echo capture.
- timeout  out  1  one-cycle pulse when the window expires with no echo.
- echo_time  out  16  listen-counter value at capture; holds until next capture.

## Operation
- States: OFF, IDLE, TX, LISTEN. Reset → OFF; all outputs 0, level 0.
- Commands are sampled only when `valid`=1; flags with `valid`=0 are ignored.
- `off` has top priority: any state → OFF next cycle. An in-progress burst or listen is aborted, tx_out→0, and no echo_detected/timeout pulse is generated. `level` is retained.
- OFF: `on` → IDLE. All other flags are ignored, including level changes.
- Level, in any non-OFF state: increase → level = min(level+amount, LEVEL_MAX), computed at AMOUNT_WIDTH+1 bits. Decrease → level = max(level−amount, 0). If increase and decrease are both set, both are ignored. A level change during TX does not alter `tx_amp`.
- IDLE, send=1, level≠0 → TX. `tx_amp`←level. `receive` in the same word is latched as listen_req.
- IDLE, send=1, level=0 → the send is ignored.
- IDLE, receive=1, send=0 → LISTEN.
- TX: tx_out high HALF_PERIOD cycles, then low HALF_PERIOD cycles, repeated BURST_LEN times. At the end, go to LISTEN if listen_req is set, otherwise IDLE.
- LISTEN: the counter starts at 0 on the first LISTEN cycle and increments each cycle.
  - A rising edge of the (optionally synchronized) echo is detected as current=1 and previous=0. The previous-sample register updates every cycle, so a level already high on LISTEN entry is not an edge.
  - On an edge: echo_time←count, pulse echo_detected, go to IDLE.
  - If count reaches LISTEN_CYCLES−1 with no edge: pulse timeout, go to IDLE.
  - An edge on the last window cycle wins over timeout.
- send and receive arriving in TX or LISTEN are ignored. Level commands are still honoured.

## Timing
- Command sampled at edge T; the state and level change is visible after edge T+1 (one-cycle latency).
- TX: tx_out=1 starting in the first TX cycle. TX occupies exactly 2·HALF_PERIOD·BURST_LEN cycles.
- echo_detected, timeout and the echo_time update are registered and asserted in the last LISTEN cycle. busy drops the following cycle.
- Async reset mid-burst forces tx_out=0 and state OFF immediately.

## Configuration
- ECHO_SYNC_EN defined: echo_in passes through a 2-flop synchronizer before edge detection. This adds 2 cycles of echo latency, and echo_time is not compensated for it.
- ECHO_SYNC_EN undefined: echo_in is used directly and must already be synchronous to clk.

## Structure
- Package ultrasonic_pkg holds:
  - the state enum (OFF/IDLE/TX/LISTEN);
  - the 16-bit echo_time width constant;
  - a function for the level saturation arithmetic.
- Sub-module us_burst_gen (start, abort, HALF_PERIOD/BURST_LEN parameters → tx_out, done) is a natural split. The FSM, level logic and listen timer stay at top level.

## Test plan
- Reset, then valid{on}, then valid{increase, amount=150} twice → level=150, then 200 (saturated); valid{decrease, amount=250} → level 0.
- Powered, level=50, valid{send} → busy for 64 cycles; tx_out toggles every 4 cycles, starting high; tx_amp=50; returns to IDLE with no listen.
- valid{send, receive}, echo_in rising 10 cycles into LISTEN → echo_detected pulse, echo_time=10 (12 when ECHO_SYNC_EN is defined).
- valid{receive}, echo_in held low → timeout pulse after 64 LISTEN cycles, then IDLE; echo_time unchanged.
- valid{off} at cycle 20 of TX → tx_out 0 next cycle, state OFF, no pulses; a following valid{send} is ignored until valid{on}.
- valid=0 with send=1 in IDLE → no action; valid{increase, decrease} together → level unchanged; level=0 with valid{send} → no burst.
